sfm_ctrl_cntx_mgr: RTL

Parametrised job-context manager for the softmax accelerator control path. It holds `N_CNTX` programmable register contexts, each of `N_REGS` words, and queues committed jobs in order to the datapath controller. It also keeps `N_SLOTS` saved partial-softmax states (max, denominator), so multi-pass rows can split across `CMD_ACC_ONLY` and `CMD_DIV_ONLY` jobs. It sits between the peripheral config port and the datapath control FSM, replacing the fixed two-context, four-register scheme with one generalised in width, depth and slot count.

---
 rtl/sfm_ctrl_cntx_mgr.sv | 119 +++++++++++
 1 files changed

// File: rtl/sfm_ctrl_cntx_mgr.sv
// sfm_ctrl_cntx_mgr: ring of job register contexts dispatched in order, with saved partial-softmax slots
module sfm_ctrl_cntx_mgr #(
  parameter int N_CNTX    = 2,
  parameter int N_REGS    = 4,
  parameter int N_SLOTS   = 2,
  parameter int REG_W     = 32,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_ACC = 32,
  localparam int AW = $clog2(N_REGS + 2),
  localparam int SW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1,
  localparam int CW = $clog2(N_CNTX)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_req_i,
  input  logic                    cfg_we_i,
  input  logic [AW-1:0]           cfg_addr_i,
  input  logic [REG_W-1:0]        cfg_wdata_i,
  output logic                    cfg_gnt_o,
  output logic                    cfg_rvalid_o,
  output logic [REG_W-1:0]        cfg_rdata_o,
  output logic                    job_valid_o,
  input  logic                    job_ready_i,
  output logic [N_REGS*REG_W-1:0] job_regs_o,
  output logic [CW-1:0]           job_id_o,
  input  logic                    done_i,
  input  logic [WIDTH_IN-1:0]     res_max_i,
  input  logic [WIDTH_ACC-1:0]    res_den_i,
  output logic                    slot_valid_o,
  output logic [WIDTH_IN-1:0]     slot_max_o,
  output logic [WIDTH_ACC-1:0]    slot_den_o,
  output logic                    evt_o
);
  localparam int RW = $clog2(N_REGS);
  localparam int NW = $clog2(N_CNTX + 1);
  logic [REG_W-1:0] ctx [N_CNTX][N_REGS];
  logic [CW-1:0] wp, dp, run_id;
  logic [NW-1:0] cnt;
  logic running, full, wr, rd, reg_wr, trig, fin, take;
  logic [N_SLOTS-1:0] slot_vld;
  logic [WIDTH_IN-1:0] slot_max [N_SLOTS];
  logic [WIDTH_ACC-1:0] slot_den [N_SLOTS];
  logic [REG_W-1:0] status, job_cmd, run_cmd;
  logic [SW-1:0] job_slot, run_slot;

  function automatic logic [SW-1:0] slot_of(input logic [REG_W-1:0] c);
    return int'(c[8 +: SW]) >= N_SLOTS ? SW'(N_SLOTS - 1) : c[8 +: SW];
  endfunction

  always_comb begin
    full = cnt == NW'(N_CNTX);
    cfg_gnt_o = cfg_req_i && (!cfg_we_i || !full);
    wr = cfg_gnt_o && cfg_we_i;
    rd = cfg_gnt_o && !cfg_we_i;
    reg_wr = wr && cfg_addr_i < AW'(N_REGS);
    trig = wr && cfg_addr_i == AW'(N_REGS);
    fin = done_i && running;
    job_valid_o = cnt != '0 && !running;
    take = job_valid_o && job_ready_i;
    job_id_o = dp;
    job_cmd = ctx[dp][3];
    run_cmd = ctx[run_id][3];
    job_slot = slot_of(job_cmd);
    run_slot = slot_of(run_cmd);
    slot_valid_o = slot_vld[job_slot];
    slot_max_o = slot_max[job_slot];
    slot_den_o = slot_den[job_slot];
    status = '0;
    status[0] = running;
    status[1] = full;
    status[15:8] = 8'(cnt);
    status[23:16] = running ? 8'(run_id) : 8'h0;
    job_regs_o = '0;
    for (int r = 0; r < N_REGS; r++) job_regs_o[r*REG_W +: REG_W] = ctx[dp][r];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp <= '0;
      dp <= '0;
      run_id <= '0;
      cnt <= '0;
      running <= 1'b0;
      slot_vld <= '0;
      evt_o <= 1'b0;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o <= '0;
      for (int c = 0; c < N_CNTX; c++)
        for (int r = 0; r < N_REGS; r++) ctx[c][r] <= '0;
      for (int s = 0; s < N_SLOTS; s++) begin
        slot_max[s] <= '0;
        slot_den[s] <= '0;
      end
    end else begin
      cfg_rvalid_o <= rd;
      cfg_rdata_o <= !rd ? '0 :
                     cfg_addr_i < AW'(N_REGS) ? ctx[wp][RW'(cfg_addr_i)] :
                     cfg_addr_i == AW'(N_REGS + 1) ? status : '0;
      evt_o <= fin;
      cnt <= cnt + NW'(trig) - NW'(fin);
      if (reg_wr) ctx[wp][RW'(cfg_addr_i)] <= cfg_wdata_i;
      if (trig) wp <= wp == CW'(N_CNTX - 1) ? '0 : wp + 1'b1;
      if (take) begin
        running <= 1'b1;
        run_id <= dp;
        dp <= dp == CW'(N_CNTX - 1) ? '0 : dp + 1'b1;
      end
      if (fin) begin
        running <= 1'b0;
        if (run_cmd[0]) begin
          slot_vld[run_slot] <= 1'b1;
          slot_max[run_slot] <= res_max_i;
          slot_den[run_slot] <= res_den_i;
        end
        if (run_cmd[1] && run_cmd[2]) slot_vld[run_slot] <= 1'b0;
      end
    end
  end
endmodule
